// File: rtl/key_scan_pkg.sv
// Shared types and key map for the 4x4 keypad scanner.
// Imported by the scanner top and its helpers.
package key_scan_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CAND,
      PRESSED,
      RELEASE
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } result_t;

   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   function automatic logic [3:0] keymap(
      input logic [1:0] row,
      input logic [1:0] col
   );
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = KEY_STAR;
         4'b11_01: code = 4'h0;
         4'b11_10: code = KEY_HASH;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/module_key_scan_sync2.sv
// Two-flop synchronizer with a synchronous reset value.
// Used to bring the asynchronous keypad rows into the clock domain.
module module_sync2 #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/module_key_scan.sv
// 4x4 keypad scanner: column drive, row sampling, whole-scan debounce
// and a single-cycle strobe per accepted press.
module module_key_scan
   import key_scan_pkg::*;
#(
   parameter int SCAN_TICKS     = 27000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] column,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int TW = $clog2(SCAN_TICKS);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   logic [TW-1:0]   tick;
   logic [1:0]      col_idx;
   logic [3:0]      row_s;
   logic [2:0][3:0] hits;
   logic            last_tick;

   module_sync2 #(.WIDTH(4), .RST_VAL(4'b1111)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (row),
      .q   (row_s)
   );

   assign last_tick = (tick == TW'(SCAN_TICKS - 1));
   assign column    = ~(4'b0001 << col_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         tick    <= '0;
         col_idx <= 2'd0;
         hits    <= '0;
      end else if (last_tick) begin
         tick    <= '0;
         col_idx <= col_idx + 2'd1;
         for (int c = 0; c < 3; c++)
            if (col_idx == 2'(c)) hits[c] <= ~row_s;
      end else begin
         tick <= tick + TW'(1);
      end
   end

   // Column 3 is taken live so the result is ready at its sample edge.
   logic [3:0][3:0] cur;
   logic [1:0]      n_keys;
   logic [3:0]      k_next;
   result_t         res_next;

   always_comb begin
      cur    = {~row_s, hits};
      n_keys = 2'd0;
      k_next = 4'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (cur[c][r]) begin
               if (n_keys != 2'd2) n_keys = n_keys + 2'd1;
               k_next = keymap(2'(r), 2'(c));
            end
         end
      end
      case (n_keys)
         2'd0:    res_next = NONE;
         2'd1:    res_next = SINGLE;
         default: res_next = MULTI;
      endcase
   end

   logic       res_valid;
   result_t    res;
   logic [3:0] res_key;

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res       <= NONE;
         res_key   <= 4'h0;
      end else begin
         res_valid <= last_tick && (col_idx == 2'd3);
         res       <= res_next;
         res_key   <= k_next;
      end
   end

   state_t        state, state_n;
   logic [3:0]    cand, cand_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    code_n;
   logic          valid_n, held_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cand      <= 4'h0;
         cnt       <= '0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_n;
         cand      <= cand_n;
         cnt       <= cnt_n;
         key_code  <= code_n;
         key_valid <= valid_n;
         key_held  <= held_n;
      end
   end

   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      code_n  = key_code;
      valid_n = 1'b0;
      held_n  = key_held;
      if (res_valid) begin
         unique case (state)
            IDLE: begin
               if (res == SINGLE) begin
                  state_n = CAND;
                  cand_n  = res_key;
                  cnt_n   = CW'(1);
               end
            end
            CAND: begin
               if (res == SINGLE && res_key == cand) begin
                  if (cnt >= CW'(DEBOUNCE_SCANS - 1)) begin
                     state_n = PRESSED;
                     cnt_n   = CW'(DEBOUNCE_SCANS);
                     code_n  = cand;
                     valid_n = 1'b1;
                     held_n  = 1'b1;
                  end else begin
                     cnt_n = cnt + CW'(1);
                  end
               end else if (res == SINGLE) begin
                  cand_n = res_key;
                  cnt_n  = CW'(1);
               end else begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end
            end
            PRESSED: begin
               if (res == NONE) begin
                  state_n = RELEASE;
                  cnt_n   = CW'(1);
               end
            end
            RELEASE: begin
               if (res != NONE) begin
                  state_n = PRESSED;
                  cnt_n   = '0;
               end else if (cnt >= CW'(DEBOUNCE_SCANS - 1)) begin
                  state_n = IDLE;
                  cnt_n   = '0;
                  held_n  = 1'b0;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_module_key_scan.sv
// Bench for module_key_scan: keypad model, table-driven scenarios,
// and randomized scans against a run-length reference model.
module tb_module_key_scan;

   localparam int ST = 4;
   localparam int DB = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row;
   logic [3:0]  column;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] pressed = '0;

   always #5 clk = ~clk;

   module_key_scan #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .column    (column),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   // Passive keypad: bit r*4+c closes row r onto column c.
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !column[c]) row[r] = 1'b0;
   end

   logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                             4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC,
                             4'hE, 4'h0, 4'hF, 4'hD};

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int n_strobe = 0;

   bit         m_held;
   logic [3:0] m_code;
   int         m_key;
   int         m_run;
   int         m_none;

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                    name, act, exp, cyc);
   endtask

   task automatic model_reset();
      m_held = 1'b0;
      m_code = 4'h0;
      m_key  = -1;
      m_run  = 0;
      m_none = 0;
   endtask

   // Acceptance = DB consecutive scans of the same lone key while not
   // held; release = DB consecutive empty scans while held.
   task automatic model_scan(input logic [15:0] m, output bit strobe);
      int n, k;
      n = $countones(m);
      k = -1;
      for (int b = 0; b < 16; b++) if (m[b]) k = b;
      strobe = 1'b0;
      if (!m_held) begin
         if (n == 1) begin
            if (m_run > 0 && k == m_key) m_run++;
            else begin
               m_run = 1;
               m_key = k;
            end
            if (m_run == DB) begin
               strobe = 1'b1;
               m_held = 1'b1;
               m_code = kmap[k];
               m_none = 0;
            end
         end else m_run = 0;
      end else if (n == 0) begin
         m_none++;
         if (m_none == DB) begin
            m_held = 1'b0;
            m_run  = 0;
         end
      end else m_none = 0;
   endtask

   task automatic step(input bit exp_valid);
      logic [3:0] one;
      logic [3:0] exp_col;
      one = 4'b0001;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      exp_col = ~(one << ((cyc / ST) % 4));
      if (key_valid === 1'b1) n_strobe++;
      chk("column", 16'(column), 16'(exp_col));
      chk("key_valid", 16'(key_valid), 16'(exp_valid));
      chk("key_code", 16'(key_code), 16'(m_code));
      chk("key_held", 16'(key_held), 16'(m_held));
   endtask

   task automatic run_scan(input logic [15:0] m);
      bit s;
      pressed = m;
      s = 1'b0;
      for (int j = 1; j <= 16; j++) begin
         if (j == 16) model_scan(m, s);
         step(j == 16 && s);
      end
   endtask

   task automatic partial(input int n, input logic [15:0] m);
      pressed = m;
      for (int j = 0; j < n; j++) step(1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_column", 16'(column), 16'h000E);
      chk("rst_valid", 16'(key_valid), 16'h0);
      chk("rst_held", 16'(key_held), 16'h0);
      chk("rst_code", 16'(key_code), 16'h0);
      rst = 1'b0;
      cyc = 0;
      model_reset();
      step(1'b0);
   endtask

   typedef struct {
      logic [15:0] mask;
      int          scans;
      bit          alt;
      bit          rst_after;
      int          strobes;
      logic [3:0]  code;
      logic        held;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [15:0] mask, input int scans,
                      input bit alt, input bit rst_after,
                      input int strobes, input logic [3:0] code,
                      input logic held);
      vec_t v;
      v.mask = mask;
      v.scans = scans;
      v.alt = alt;
      v.rst_after = rst_after;
      v.strobes = strobes;
      v.code = code;
      v.held = held;
      vecs.push_back(v);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int s0;
      logic [15:0] m;
      int pool [3];
      model_reset();

      add(16'h0000, 10, 0, 0, 0, 4'h0, 1'b0);
      add(16'h0040,  6, 0, 0, 1, 4'h6, 1'b1);
      add(16'h0000,  2, 0, 0, 0, 4'h6, 1'b1);
      add(16'h0000,  2, 0, 0, 0, 4'h6, 1'b0);
      add(16'h1000,  8, 1, 0, 0, 4'h6, 1'b0);
      add(16'h1000,  4, 0, 0, 1, 4'hE, 1'b1);
      add(16'h0000,  3, 0, 0, 0, 4'hE, 1'b0);
      add(16'h0001,  3, 0, 0, 1, 4'h1, 1'b1);
      add(16'h0201,  3, 0, 0, 0, 4'h1, 1'b1);
      add(16'h0200,  3, 0, 0, 0, 4'h1, 1'b1);
      add(16'h0000,  3, 0, 0, 0, 4'h1, 1'b0);
      add(16'h0200,  3, 0, 0, 1, 4'h8, 1'b1);
      add(16'h0000,  3, 0, 0, 0, 4'h8, 1'b0);
      add(16'h0088,  4, 0, 0, 0, 4'h8, 1'b0);
      add(16'h0040,  3, 0, 0, 1, 4'h6, 1'b1);
      add(16'h0000,  2, 0, 0, 0, 4'h6, 1'b1);
      add(16'h0040,  1, 0, 0, 0, 4'h6, 1'b1);
      add(16'h0000,  3, 0, 0, 0, 4'h6, 1'b0);
      add(16'h0001,  2, 0, 0, 0, 4'h6, 1'b0);
      add(16'h0200,  3, 0, 0, 1, 4'h8, 1'b1);
      add(16'h0000,  3, 0, 0, 0, 4'h8, 1'b0);
      add(16'h4000,  3, 0, 0, 1, 4'hF, 1'b1);
      add(16'h0000,  3, 0, 0, 0, 4'hF, 1'b0);
      add(16'h8000,  2, 0, 1, 0, 4'hF, 1'b0);
      add(16'h8000,  3, 0, 0, 1, 4'hD, 1'b1);
      add(16'h0000,  3, 0, 0, 0, 4'hD, 1'b0);

      do_reset();

      foreach (vecs[e]) begin
         s0 = n_strobe;
         for (int i = 0; i < vecs[e].scans; i++) begin
            m = (vecs[e].alt && (i % 2 == 1)) ? 16'h0 : vecs[e].mask;
            run_scan(m);
         end
         chk($sformatf("v%0d_strobes", e), 16'(n_strobe - s0),
             16'(vecs[e].strobes));
         chk($sformatf("v%0d_code", e), 16'(key_code), 16'(vecs[e].code));
         chk($sformatf("v%0d_held", e), 16'(key_held), 16'(vecs[e].held));
         if (vecs[e].rst_after) begin
            partial(5, vecs[e].mask);
            do_reset();
         end
      end

      for (int i = 0; i < 3; i++) pool[i] = $urandom_range(0, 15);
      for (int it = 0; it < 60; it++) begin
         int t, a, b, n;
         t = $urandom_range(0, 99);
         if (t < 35) m = 16'h0;
         else if (t < 80) m = 16'h1 << pool[$urandom_range(0, 2)];
         else begin
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            m = (16'h1 << a) | (16'h1 << b);
         end
         n = $urandom_range(1, 4);
         for (int s = 0; s < n; s++) run_scan(m);
         if ($urandom_range(0, 19) == 0) begin
            partial($urandom_range(1, 14), m);
            do_reset();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
